lsu: RTL

- Load/store unit directly downstream of the execute stage.
- Consumes the execute stage's memory request (read/write enable, address, store data) plus the instruction word.
- Performs misalignment checks, byte-lane steering and a valid/ready transaction on the data bus, with a response timeout.
- Writes load results back to the register file and stalls the pipeline while an access is outstanding.

---
 rtl/lsu.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : lsu
//  Purpose  : Load/store unit behind the execute stage. Checks alignment,
//             steers store bytes onto the four bus lanes, runs a valid/ready
//             request followed by a response wait with timeout, and returns
//             extended load data to the register file.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             inst                - instruction (funct3 = [14:12], rd = [11:7])
//             mem_read_*          - load request from execute
//             mem_write_*         - store request from execute
//             bus_req_*/bus_addr/bus_we/bus_wstrb/bus_wdata - bus request
//             bus_resp_valid/bus_rdata                      - bus response
//             stall               - hold upstream stages
//             regs_write_*        - load writeback pulse
//             misaligned          - pulse, access dropped
//             bus_error           - pulse, response timeout
//  Revision : 1.0 - initial release
// ============================================================================
module lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] inst,
  input  logic            mem_read_en,
  input  logic [XLEN-1:0] mem_read_addr,
  input  logic            mem_write_en,
  input  logic [XLEN-1:0] mem_write_addr,
  input  logic [XLEN-1:0] mem_write_data,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic [XLEN-1:0] bus_addr,
  output logic            bus_we,
  output logic [3:0]      bus_wstrb,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_resp_valid,
  input  logic [XLEN-1:0] bus_rdata,
  output logic            stall,
  output logic            regs_write_en,
  output logic [4:0]      regs_write_addr,
  output logic [XLEN-1:0] regs_write_data,
  output logic            misaligned,
  output logic            bus_error
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam int         CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_addr;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_wdata;
  logic [3:0]      r_wstrb;
  logic [CW-1:0]   r_cnt;
  logic            r_misaligned;
  logic            r_bus_error;
  logic            r_wb_en;
  logic [4:0]      r_wb_addr;
  logic [XLEN-1:0] r_wb_data;

  logic [2:0]      w_funct3;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_addr;
  logic [1:0]      w_off;
  logic            w_accept;
  logic            w_size_byte;
  logic            w_size_half;
  logic            w_misalign;
  logic [3:0]      w_wstrb;
  logic [XLEN-1:0] w_wdata;
  logic [7:0]      w_lbyte;
  logic [15:0]     w_lhalf;
  logic            w_sext;
  logic [XLEN-1:0] w_load_val;
  logic            w_resp;
  logic            w_timeout;

  // Bits of the instruction word this unit does not decode.
  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, inst[XLEN-1:15], inst[6:0]};

  assign w_funct3 = inst[14:12];
  assign w_rd     = inst[11:7];
  // A store has priority over a simultaneous load.
  assign w_addr   = mem_write_en ? mem_write_addr : mem_read_addr;
  assign w_off    = w_addr[1:0];
  assign w_accept = (r_state == S_IDLE) && (mem_write_en || mem_read_en);

  // Stores only know SB/SH/SW; loads also have the unsigned byte/half
  // forms (funct3[2] set). Everything else is treated as a word access.
  always_comb begin
    w_size_byte = 1'b0;
    w_size_half = 1'b0;
    if (mem_write_en) begin
      w_size_byte = (w_funct3 == 3'b000);
      w_size_half = (w_funct3 == 3'b001);
    end else begin
      w_size_byte = (w_funct3[1:0] == 2'b00);
      w_size_half = (w_funct3[1:0] == 2'b01);
    end
  end

  assign w_misalign = w_size_half ? w_off[0] : (!w_size_byte && (w_off != 2'b00));

  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = mem_write_data;
    if (w_size_byte) begin
      w_wstrb = 4'b0001 << w_off;
      w_wdata = {(XLEN/8){mem_write_data[7:0]}};
    end else if (w_size_half) begin
      w_wstrb = 4'b0011 << w_off;
      w_wdata = {(XLEN/16){mem_write_data[15:0]}};
    end
  end

  // Load extraction from the registered byte offset of the access.
  assign w_lbyte = bus_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_lhalf = bus_rdata[{r_addr[1], 4'b0000} +: 16];
  assign w_sext  = ~r_funct3[2];

  always_comb begin
    w_load_val = bus_rdata;
    if (r_funct3[1:0] == 2'b00)
      w_load_val = {{(XLEN-8){w_sext & w_lbyte[7]}}, w_lbyte};
    else if (r_funct3[1:0] == 2'b01)
      w_load_val = {{(XLEN-16){w_sext & w_lhalf[15]}}, w_lhalf};
  end

  // The counter holds the number of completed WAIT cycles, so the
  // TIMEOUT-th WAIT cycle is the one where it equals TIMEOUT-1.
  assign w_resp    = (r_state == S_WAIT) && bus_resp_valid;
  assign w_timeout = (r_state == S_WAIT) && !bus_resp_valid && (r_cnt == C_CNT_LAST);

  assign bus_req_valid   = (r_state == S_REQ);
  assign bus_addr        = bus_req_valid ? {r_addr[XLEN-1:2], 2'b00} : '0;
  assign bus_we          = bus_req_valid & r_we;
  assign bus_wstrb       = bus_req_valid ? r_wstrb : 4'b0000;
  assign bus_wdata       = bus_req_valid ? r_wdata : '0;
  assign stall           = (w_accept && !w_misalign) || (r_state == S_REQ) ||
                           ((r_state == S_WAIT) && !w_resp && !w_timeout);
  assign regs_write_en   = r_wb_en;
  assign regs_write_addr = r_wb_addr;
  assign regs_write_data = r_wb_data;
  assign misaligned      = r_misaligned;
  assign bus_error       = r_bus_error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_funct3     <= 3'b000;
      r_rd         <= 5'd0;
      r_wdata      <= '0;
      r_wstrb      <= 4'b0000;
      r_cnt        <= '0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      r_wb_en      <= 1'b0;
      r_wb_addr    <= 5'd0;
      r_wb_data    <= '0;
    end else begin
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      r_wb_en      <= 1'b0;
      r_wb_addr    <= 5'd0;
      r_wb_data    <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_misalign) begin
              r_misaligned <= 1'b1;
            end else begin
              r_addr   <= w_addr;
              r_we     <= mem_write_en;
              r_funct3 <= w_funct3;
              r_rd     <= w_rd;
              r_wstrb  <= mem_write_en ? w_wstrb : 4'b0000;
              r_wdata  <= mem_write_en ? w_wdata : '0;
              r_state  <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus_req_ready) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_resp) begin
            r_state <= S_IDLE;
            if (!r_we && (r_rd != 5'd0)) begin
              r_wb_en   <= 1'b1;
              r_wb_addr <= r_rd;
              r_wb_data <= w_load_val;
            end
          end else if (w_timeout) begin
            r_bus_error <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
